// File: rtl/fetch_bpred.sv
// Fetch stage with a static branch predictor (backward B-type and JAL taken).
// Optional BP_STATS_EN adds saturating resolve/mispredict counters.
module fetch_bpred #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset_n,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        stall,
    input  logic        ex_resolve,
    input  logic        ex_mispredict,
    input  logic [31:0] ex_target,
    output logic        if_valid,
    output logic [31:0] if_pc,
    output logic [31:0] if_instr,
    output logic        if_pred_taken,
    output logic [31:0] if_pred_target
`ifdef BP_STATS_EN
    ,
    output logic [31:0] stat_branches,
    output logic [31:0] stat_mispredicts
`endif
);

    localparam logic [6:0]  OP_BRANCH = 7'b1100011;
    localparam logic [6:0]  OP_JAL    = 7'b1101111;
    localparam logic [31:0] NOP       = 32'h0000_0013;

    logic [31:0] pc;
    logic [31:0] imm_b;
    logic [31:0] imm_j;
    logic [31:0] seq_pc;
    logic [31:0] pred_target;
    logic        is_branch;
    logic        is_jal;
    logic        pred_taken;

    assign imem_addr = pc;

    always_comb begin
        imm_b       = {{20{imem_rdata[31]}}, imem_rdata[7], imem_rdata[30:25],
                       imem_rdata[11:8], 1'b0};
        imm_j       = {{12{imem_rdata[31]}}, imem_rdata[19:12], imem_rdata[20],
                       imem_rdata[30:21], 1'b0};
        is_branch   = (imem_rdata[6:0] == OP_BRANCH);
        is_jal      = (imem_rdata[6:0] == OP_JAL);
        seq_pc      = pc + 32'd4;
        // Backward branches are assumed to be loop closers, hence taken.
        pred_taken  = is_jal || (is_branch && imem_rdata[31]);
        pred_target = seq_pc;
        if (is_jal)
            pred_target = pc + imm_j;
        else if (is_branch && imem_rdata[31])
            pred_target = pc + imm_b;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pc             <= RESET_PC;
            if_valid       <= 1'b0;
            if_pc          <= 32'h0;
            if_instr       <= NOP;
            if_pred_taken  <= 1'b0;
            if_pred_target <= 32'h0;
        end else if (ex_mispredict) begin
            // Redirect wins over stall; the flushed slot becomes a one-cycle bubble.
            pc       <= {ex_target[31:2], 2'b00};
            if_valid <= 1'b0;
        end else if (!stall) begin
            pc             <= pred_target;
            if_valid       <= 1'b1;
            if_pc          <= pc;
            if_instr       <= imem_rdata;
            if_pred_taken  <= pred_taken;
            if_pred_target <= pred_target;
        end
    end

`ifdef BP_STATS_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stat_branches    <= 32'h0;
            stat_mispredicts <= 32'h0;
        end else begin
            if (ex_resolve && (stat_branches != 32'hFFFF_FFFF))
                stat_branches <= stat_branches + 32'd1;
            if (ex_mispredict && (stat_mispredicts != 32'hFFFF_FFFF))
                stat_mispredicts <= stat_mispredicts + 32'd1;
        end
    end

    logic [1:0] unused_tgt_lsb;
    assign unused_tgt_lsb = ex_target[1:0];
`else
    logic [2:0] unused_in;
    assign unused_in = {ex_resolve, ex_target[1:0]};
`endif

endmodule

// File: doc/fetch_bpred.md
FETCH_BPRED -- requirements
Module: fetch_bpred

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, giving the first fetch address after reset.
REQ-002 SHALL have port clk  input  1  single system clock; all state updates on the rising edge.
REQ-003 SHALL have port reset_n  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port imem_addr  output  32  current PC presented to instruction memory.
REQ-005 SHALL have port imem_rdata  input  32  instruction at imem_addr, valid in the same cycle (combinational read).
REQ-006 SHALL have port stall  input  1  holds the PC and all if_* outputs.
REQ-007 SHALL have port ex_resolve  input  1  a control-transfer instruction resolved in execute this cycle.
REQ-008 SHALL have port ex_mispredict  input  1  the execute stage requests a redirect.
REQ-009 SHALL have port ex_target  input  32  correct next PC when ex_mispredict=1.
REQ-010 SHALL have output ports if_valid (1), if_pc (32), if_instr (32), if_pred_taken (1) and if_pred_target (32), forming the registered fetch-to-decode bundle.
REQ-011 SHALL have output ports stat_branches (32) and stat_mispredicts (32), present only under BP_STATS_EN.

Function
REQ-012 SHALL hold the PC in a 32-bit register; imem_addr SHALL equal the PC.
REQ-013 SHALL apply static prediction to imem_rdata:
- B-type (opcode 1100011) with negative immediate: predicted taken, target PC+immB.
- B-type with non-negative immediate: predicted not-taken.
- JAL (1101111): always taken, target PC+immJ.
- All other instructions, including JALR: not-taken, next PC = PC+4.
REQ-014 SHALL compute immB and immJ with full sign extension; all PC additions SHALL wrap modulo 2^32.
REQ-015 SHALL, when neither stall nor ex_mispredict is asserted, register PC, imem_rdata, prediction and predicted target into if_*, set if_valid=1, and load the PC with the predicted next PC. Latency is 1 cycle from imem_addr to if_*.
REQ-016 SHALL drive if_pred_target = PC+4 whenever if_pred_taken=0.
REQ-017 SHALL, when stall=1 and ex_mispredict=0, hold the PC and all if_* outputs unchanged.
REQ-018 SHALL give ex_mispredict priority over stall: load the PC with {ex_target[31:2],2'b00} and clear if_valid to 0 on the next edge (flush), independent of ex_resolve.
REQ-019 SHALL, in the cycle after a redirect, fetch from the redirect target normally unless stall is asserted.
REQ-020 SHALL not gate fetch on if_valid; the bubble after a flush lasts exactly one cycle.

Reset
REQ-021 SHALL, while reset_n=0, asynchronously force PC=RESET_PC, if_valid=0, if_pc=0, if_instr=32'h0000_0013 (NOP), if_pred_taken=0, if_pred_target=0 and both stat counters to 0.
REQ-022 SHALL present imem_addr=RESET_PC on the first rising edge after reset_n rises, making the first valid if_* bundle available one cycle later.
REQ-023 SHALL, if reset_n is asserted mid-operation (including during stall or redirect), discard all in-flight state with no pending redirect retained.

Configuration
REQ-024 SHALL, with macro BP_STATS_EN defined, increment stat_branches on each cycle with ex_resolve=1 and stat_mispredicts on each cycle with ex_mispredict=1; both counters SHALL saturate at 32'hFFFF_FFFF, count regardless of stall, and be unaffected by flushes.
REQ-025 SHALL, without BP_STATS_EN, omit both counters and their ports entirely, leaving fetch behaviour identical.

Verification
REQ-026 SHALL cover reset release with RESET_PC=0 and imem_rdata=0x00000013 -> imem_addr sequence 0x0, 0x4, 0x8; if_valid=0 until the cycle after the first edge.
REQ-027 SHALL cover PC=0x10 with imem_rdata=0xFE000EE3 (beq -4) -> if_pred_taken=1, if_pred_target=0x0C, next imem_addr=0x0C.
REQ-028 SHALL cover PC=0x20 with 0x00000463 (beq +8) -> if_pred_taken=0, next imem_addr=0x24; PC=0x20 with 0x0100006F (jal +16) -> taken, next imem_addr=0x30.
REQ-029 SHALL cover stall=1 and ex_mispredict=1 in the same cycle with ex_target=0x103 -> next imem_addr=0x100, if_valid=0 for exactly one cycle.
REQ-030 SHALL cover stall=1 for 3 cycles at PC=0x40 -> imem_addr and all if_* constant for 3 cycles; fetch resumes at 0x44.
REQ-031 SHALL cover, under BP_STATS_EN, 5 ex_resolve pulses with 2 ex_mispredict -> stat_branches=5, stat_mispredicts=2; a counter preloaded at 0xFFFFFFFF stays at 0xFFFFFFFF.
